// File: rtl/ex_alu_unit_pkg.sv
// Shared widths, tag encoding and op codes for the integer execute stage.
// Codes not listed in alu_op_e decode as NOP.
package ex_alu_unit_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 5;

    localparam logic [TAG_W-1:0] TAG_FREE = '0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 5'd0,
        OP_ADD   = 5'd1,
        OP_SUB   = 5'd2,
        OP_SLL   = 5'd3,
        OP_SRL   = 5'd4,
        OP_SRA   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_XOR   = 5'd8,
        OP_OR    = 5'd9,
        OP_AND   = 5'd10,
        OP_LUI   = 5'd11,
        OP_AUIPC = 5'd12,
        OP_JAL   = 5'd13,
        OP_JALR  = 5'd14,
        OP_BEQ   = 5'd15,
        OP_BNE   = 5'd16,
        OP_BLT   = 5'd17,
        OP_BGE   = 5'd18,
        OP_BLTU  = 5'd19,
        OP_BGEU  = 5'd20
    } alu_op_e;

    // Ops that produce a register write-back (everything from ADD through JALR).
    function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_JALR);
    endfunction

    function automatic logic op_is_branch(input logic [OP_W-1:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

endpackage

// File: rtl/ex_alu_unit_branch_cmp.sv
// Combinational conditional-branch evaluator: taken bit from operands and op.
// Non-branch and undefined op codes always report not-taken.
module ex_alu_branch_cmp
    import ex_alu_unit_pkg::*;
#(
    parameter int DATA_W = ex_alu_unit_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [OP_W-1:0]   op,
    output logic              taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (src1 == src2);
    assign lt_s = ($signed(src1) < $signed(src2));
    assign lt_u = (src1 < src2);

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQ:  taken = eq;
            OP_BNE:  taken = !eq;
            OP_BLT:  taken = lt_s;
            OP_BGE:  taken = !lt_s;
            OP_BLTU: taken = lt_u;
            OP_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_alu_unit.sv
// Integer execute stage: one op per cycle, 1-cycle registered result broadcast and redirect.
// No back-pressure; rdy low freezes all state. Define EX_ALU_PERF_EN for the redirect counter on busy_cnt.
module ex_alu_unit #(
    parameter int                          DATA_W   = ex_alu_unit_pkg::DATA_W,
    parameter int                          ADDR_W   = ex_alu_unit_pkg::ADDR_W,
    parameter int                          TAG_W    = ex_alu_unit_pkg::TAG_W,
    parameter int                          OP_W     = ex_alu_unit_pkg::OP_W,
    parameter logic [ex_alu_unit_pkg::TAG_W-1:0] TAG_FREE = ex_alu_unit_pkg::TAG_FREE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              issue_en,
    input  logic [DATA_W-1:0] issue_src1,
    input  logic [DATA_W-1:0] issue_src2,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [ADDR_W-1:0] issue_pc,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [TAG_W-1:0]  issue_dest,
    output logic              alu_rst_en,
    output logic [TAG_W-1:0]  alu_rst_tag,
    output logic [DATA_W-1:0] alu_rst_data,
    output logic              jump_en,
    output logic [ADDR_W-1:0] jump_target,
    output logic [7:0]        busy_cnt
);

    import ex_alu_unit_pkg::*;

    logic [4:0]        shamt;
    logic [DATA_W-1:0] result;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              br_taken;
    logic              bcast;
    logic              take_jump;
    logic [ADDR_W-1:0] pc_plus_imm;

    assign shamt       = issue_src2[4:0];
    assign pc_plus_imm = issue_pc + ADDR_W'(issue_imm);

    ex_alu_branch_cmp #(
        .DATA_W (DATA_W)
    ) u_branch_cmp (
        .src1  (issue_src1),
        .src2  (issue_src2),
        .op    (issue_op),
        .taken (br_taken)
    );

    always_comb begin
        result      = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (issue_op)
            OP_ADD:   result = issue_src1 + issue_src2;
            OP_SUB:   result = issue_src1 - issue_src2;
            OP_SLL:   result = issue_src1 << shamt;
            OP_SRL:   result = issue_src1 >> shamt;
            OP_SRA:   result = $signed(issue_src1) >>> shamt;
            OP_SLT:   result = DATA_W'($signed(issue_src1) < $signed(issue_src2));
            OP_SLTU:  result = DATA_W'(issue_src1 < issue_src2);
            OP_XOR:   result = issue_src1 ^ issue_src2;
            OP_OR:    result = issue_src1 | issue_src2;
            OP_AND:   result = issue_src1 & issue_src2;
            OP_LUI:   result = issue_src2;
            OP_AUIPC: result = DATA_W'(pc_plus_imm);
            OP_JAL: begin
                result      = DATA_W'(issue_pc + ADDR_W'(4));
                redirect    = 1'b1;
                redirect_pc = pc_plus_imm;
            end
            OP_JALR: begin
                result      = DATA_W'(issue_pc + ADDR_W'(4));
                redirect    = 1'b1;
                // Bit 0 of a register-indirect target is always discarded.
                redirect_pc = ADDR_W'(issue_src1 + issue_imm) & ~ADDR_W'(1);
            end
            default: begin
                if (op_is_branch(issue_op) && br_taken) begin
                    redirect    = 1'b1;
                    redirect_pc = pc_plus_imm;
                end
            end
        endcase
    end

    assign bcast     = issue_en && op_writes_reg(issue_op) && (issue_dest != TAG_FREE);
    assign take_jump = issue_en && redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_rst_en   <= 1'b0;
            alu_rst_tag  <= TAG_FREE;
            alu_rst_data <= '0;
            jump_en      <= 1'b0;
            jump_target  <= '0;
        end else if (rdy) begin
            alu_rst_en   <= bcast;
            alu_rst_tag  <= bcast ? issue_dest : TAG_FREE;
            alu_rst_data <= bcast ? result : '0;
            jump_en      <= take_jump;
            jump_target  <= take_jump ? redirect_pc : '0;
        end
    end

`ifdef EX_ALU_PERF_EN
    logic [7:0] redirect_cnt;

    // Counts every accepted op that redirects, so back-to-back jumps each count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt <= 8'd0;
        end else if (rdy && take_jump && (redirect_cnt != 8'hFF)) begin
            redirect_cnt <= redirect_cnt + 8'd1;
        end
    end

    assign busy_cnt = redirect_cnt;
`else
    assign busy_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed cases plus random ops against a behavioural model.
module tb_ex_alu_unit;
    import ex_alu_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        issue_en;
    logic [31:0] issue_src1, issue_src2, issue_imm, issue_pc;
    logic [4:0]  issue_op;
    logic [3:0]  issue_dest;
    logic        alu_rst_en;
    logic [3:0]  alu_rst_tag;
    logic [31:0] alu_rst_data;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [7:0]  busy_cnt;

    ex_alu_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .issue_en     (issue_en),
        .issue_src1   (issue_src1),
        .issue_src2   (issue_src2),
        .issue_imm    (issue_imm),
        .issue_pc     (issue_pc),
        .issue_op     (issue_op),
        .issue_dest   (issue_dest),
        .alu_rst_en   (alu_rst_en),
        .alu_rst_tag  (alu_rst_tag),
        .alu_rst_data (alu_rst_data),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .busy_cnt     (busy_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic        e_en;
    logic [3:0]  e_tag;
    logic [31:0] e_data;
    logic        e_jen;
    logic [31:0] e_tgt;
    int          e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".en"},   32'(alu_rst_en),  32'(e_en));
        chk({ctx, ".tag"},  32'(alu_rst_tag), 32'(e_tag));
        chk({ctx, ".data"}, alu_rst_data,     e_data);
        chk({ctx, ".jen"},  32'(jump_en),     32'(e_jen));
        chk({ctx, ".tgt"},  jump_target,      e_tgt);
        chk({ctx, ".cnt"},  32'(busy_cnt),    32'(e_cnt));
    endtask

    // Architectural meaning of each op, written straight from the op definitions.
    task automatic model(input logic [4:0] op, input logic [31:0] s1, s2, imm, pc,
                         output logic wr, output logic [31:0] res,
                         output logic jmp, output logic [31:0] tgt);
        int sh;
        sh  = int'(s2 % 32);
        wr  = 1'b1;
        res = 32'd0;
        jmp = 1'b0;
        tgt = 32'd0;
        case (op)
            OP_ADD:   res = s1 + s2;
            OP_SUB:   res = s1 - s2;
            OP_SLL:   res = s1 << sh;
            OP_SRL:   res = s1 >> sh;
            OP_SRA:   res = 32'(int'(s1) >>> sh);
            OP_SLT:   res = (int'(s1) < int'(s2)) ? 32'd1 : 32'd0;
            OP_SLTU:  res = (s1 < s2) ? 32'd1 : 32'd0;
            OP_XOR:   res = s1 ^ s2;
            OP_OR:    res = s1 | s2;
            OP_AND:   res = s1 & s2;
            OP_LUI:   res = s2;
            OP_AUIPC: res = pc + imm;
            OP_JAL:   begin res = pc + 4; jmp = 1'b1; tgt = pc + imm; end
            OP_JALR:  begin res = pc + 4; jmp = 1'b1; tgt = (s1 + imm) & 32'hFFFF_FFFE; end
            OP_BEQ:   begin wr = 1'b0; jmp = (s1 == s2); end
            OP_BNE:   begin wr = 1'b0; jmp = (s1 != s2); end
            OP_BLT:   begin wr = 1'b0; jmp = (int'(s1) < int'(s2)); end
            OP_BGE:   begin wr = 1'b0; jmp = (int'(s1) >= int'(s2)); end
            OP_BLTU:  begin wr = 1'b0; jmp = (s1 < s2); end
            OP_BGEU:  begin wr = 1'b0; jmp = (s1 >= s2); end
            default:  wr = 1'b0;
        endcase
        if (op >= OP_BEQ && op <= OP_BGEU && jmp) tgt = pc + imm;
    endtask

    task automatic step(input logic r, input logic en, input logic [4:0] op,
                        input logic [31:0] s1, s2, imm, pc, input logic [3:0] dest,
                        input string ctx);
        logic        wr, jmp;
        logic [31:0] res, tgt;
        rdy        = r;
        issue_en   = en;
        issue_op   = op;
        issue_src1 = s1;
        issue_src2 = s2;
        issue_imm  = imm;
        issue_pc   = pc;
        issue_dest = dest;
        if (r) begin
            model(op, s1, s2, imm, pc, wr, res, jmp, tgt);
            e_en   = en && wr && (dest != TAG_FREE);
            e_tag  = e_en ? dest : TAG_FREE;
            e_data = e_en ? res : 32'd0;
            e_jen  = en && jmp;
            e_tgt  = e_jen ? tgt : 32'd0;
`ifdef EX_ALU_PERF_EN
            if (e_jen && e_cnt < 255) e_cnt++;
`endif
        end
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic clear_exp();
        e_en = 1'b0; e_tag = TAG_FREE; e_data = 32'd0;
        e_jen = 1'b0; e_tgt = 32'd0; e_cnt = 0;
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b1; rdy = 1'b0; issue_en = 1'b0; issue_op = 5'd0;
        issue_src1 = 0; issue_src2 = 0; issue_imm = 0; issue_pc = 0; issue_dest = 0;
        clear_exp();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        step(1, 1, OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, "add");
        chk("add_lit", alu_rst_data, 32'd12);
        step(1, 1, OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd2, "sra");
        chk("sra_lit", alu_rst_data, 32'hF800_0000);
        step(1, 1, OP_SRL, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd2, "srl");
        chk("srl_lit", alu_rst_data, 32'h0800_0000);
        step(1, 1, OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd1, "blt");
        chk("blt_lit", jump_target, 32'h120);
        step(1, 1, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd1, "bltu");
        step(1, 1, OP_JALR, 32'h203, 32'd9, 32'd0, 32'h40, 4'd5, "jalr");
        chk("jalr_tgt", jump_target, 32'h202);
        chk("jalr_dat", alu_rst_data, 32'h44);
        step(1, 1, OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, TAG_FREE, "add_free");
        step(1, 1, OP_JAL, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h80, 4'd7, "jal");
        step(1, 1, 5'd27, 32'd1, 32'd1, 32'd4, 32'd8, 4'd6, "undef");
        step(1, 0, OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd4, "idle");

        // Freeze: a live result must survive three rdy-low cycles with new ops offered.
        step(1, 1, OP_XOR, 32'hF0F0_0000, 32'h0FF0_1234, 32'd0, 32'd0, 4'd9, "pre_hold");
        for (int i = 0; i < 3; i++)
            step(0, 1, OP_JAL, 32'd3, 32'd4, 32'd8, 32'h200, 4'd1, "hold");

        // Asynchronous reset in the middle of a cycle.
        step(1, 1, OP_JAL, 32'd0, 32'd0, 32'h10, 32'h300, 4'd8, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        clear_exp();
        check_all("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = 32'($urandom_range(0, 40)) - 32'd20;
                b = 32'($urandom_range(0, 40)) - 32'd20;
            end
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                 5'($urandom_range(0, 31)), a, b, $urandom, $urandom,
                 4'($urandom_range(0, 15)), "rand");
        end

        for (int i = 0; i < 300; i++)
            step(1, 1, OP_BEQ, 32'd7, 32'd7, 32'd8, 32'h100, 4'd0, "beq_run");
`ifdef EX_ALU_PERF_EN
        chk("perf_sat", 32'(busy_cnt), 32'd255);
`else
        chk("perf_off", 32'(busy_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
